// File: rtl/op_mode_commit_ctrl.sv
// Confirm-button commit controller: synchronises and debounces the button, decodes the
// switch mode code on a press and hands the committed mode to the datapath via req/ack.
module op_mode_commit_ctrl #(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned CODE_LSB        = 0,
  parameter int unsigned CODE_WIDTH      = 3,
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                confirm_btn,
  input  logic                calc_busy,
  output logic [2:0]          op_mode,
  output logic [2:0]          calc_type,
  output logic                mode_valid,
  output logic                cfg_req,
  input  logic                cfg_ack,
  output logic                invalid_code,
  output logic                lock_err
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // op_mode_t / calc_type_t encodings shared with the matrix datapath
  localparam logic [2:0] OP_SINGLE       = 3'd0;
  localparam logic [2:0] OP_DOUBLE       = 3'd1;
  localparam logic [2:0] OP_SCALAR       = 3'd2;
  localparam logic [2:0] CALC_TRANSPOSE  = 3'd0;
  localparam logic [2:0] CALC_ADD        = 3'd1;
  localparam logic [2:0] CALC_MUL        = 3'd2;
  localparam logic [2:0] CALC_SCALAR_MUL = 3'd3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  logic [SW_WIDTH-1:0]   sw_meta_q;
  logic [SW_WIDTH-1:0]   sw_sync_q;
  logic                  btn_meta_q;
  logic                  btn_sync_q;
  logic                  btn_prev_q;
  logic                  btn_stable_q;
  logic                  btn_stable_d;
  logic                  btn_stable_prev_q;
  logic [CNT_W-1:0]      deb_cnt_q;
  logic [CNT_W-1:0]      deb_cnt_d;
  logic                  press_c;
  logic [CODE_WIDTH-1:0] code_c;
  logic                  code_ok_c;
  logic [2:0]            dec_op_c;
  logic [2:0]            dec_calc_c;
  logic                  sw_sync_unused;

  state_t     state_q, state_d;
  logic [2:0] op_mode_q, op_mode_d;
  logic [2:0] calc_type_q, calc_type_d;
  logic       mode_valid_q, mode_valid_d;
  logic       cfg_req_q, cfg_req_d;
  logic       invalid_code_q, invalid_code_d;
  logic       lock_err_q, lock_err_d;

  // Two-flop synchronisers for the raw switch bus and the button
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= confirm_btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Count only while the synchronised level differs from the stable level and has not moved
  always_comb begin
    deb_cnt_d    = '0;
    btn_stable_d = btn_stable_q;
    if ((btn_sync_q != btn_stable_q) && (btn_sync_q == btn_prev_q)) begin
      if (deb_cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_CYCLES)) begin
        btn_stable_d = btn_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q        <= 1'b0;
      btn_stable_q      <= 1'b0;
      btn_stable_prev_q <= 1'b0;
      deb_cnt_q         <= '0;
    end else begin
      btn_prev_q        <= btn_sync_q;
      btn_stable_q      <= btn_stable_d;
      btn_stable_prev_q <= btn_stable_q;
      deb_cnt_q         <= deb_cnt_d;
    end
  end

  assign press_c        = btn_stable_q & ~btn_stable_prev_q;
  assign code_c         = sw_sync_q[CODE_LSB +: CODE_WIDTH];
  assign code_ok_c      = (32'(code_c) < NUM_MODES);
  assign sw_sync_unused = ^sw_sync_q;

  // Mode code decode
  always_comb begin
    dec_op_c   = OP_SINGLE;
    dec_calc_c = CALC_TRANSPOSE;
    case (32'(code_c))
      32'd1: begin
        dec_op_c   = OP_DOUBLE;
        dec_calc_c = CALC_ADD;
      end
      32'd2: begin
        dec_op_c   = OP_DOUBLE;
        dec_calc_c = CALC_MUL;
      end
      32'd3: begin
        dec_op_c   = OP_SCALAR;
        dec_calc_c = CALC_SCALAR_MUL;
      end
      default: begin
        dec_op_c   = OP_SINGLE;
        dec_calc_c = CALC_TRANSPOSE;
      end
    endcase
  end

  // Commit FSM: presses are only honoured in S_IDLE with the datapath free
  always_comb begin
    state_d        = state_q;
    op_mode_d      = op_mode_q;
    calc_type_d    = calc_type_q;
    mode_valid_d   = mode_valid_q;
    cfg_req_d      = cfg_req_q;
    invalid_code_d = 1'b0;
    lock_err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_c) begin
          if (calc_busy) begin
            lock_err_d = 1'b1;
          end else if (!code_ok_c) begin
            invalid_code_d = 1'b1;
          end else begin
            op_mode_d    = dec_op_c;
            calc_type_d  = dec_calc_c;
            mode_valid_d = 1'b1;
            cfg_req_d    = 1'b1;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (cfg_ack) begin
          cfg_req_d = 1'b0;
          state_d   = S_IDLE;
        end
        if (press_c) begin
          lock_err_d = 1'b1;
        end
      end
      default: begin
        cfg_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_mode_q      <= OP_SINGLE;
      calc_type_q    <= CALC_TRANSPOSE;
      mode_valid_q   <= 1'b0;
      cfg_req_q      <= 1'b0;
      invalid_code_q <= 1'b0;
      lock_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_mode_q      <= op_mode_d;
      calc_type_q    <= calc_type_d;
      mode_valid_q   <= mode_valid_d;
      cfg_req_q      <= cfg_req_d;
      invalid_code_q <= invalid_code_d;
      lock_err_q     <= lock_err_d;
    end
  end

  assign op_mode      = op_mode_q;
  assign calc_type    = calc_type_q;
  assign mode_valid   = mode_valid_q;
  assign cfg_req      = cfg_req_q;
  assign invalid_code = invalid_code_q;
  assign lock_err     = lock_err_q;

endmodule

// File: tb/tb_op_mode_commit_ctrl.sv
// Scoreboard bench for op_mode_commit_ctrl: commit/invalid/lock events are predicted when
// stimulus is driven and matched in order when the DUT produces them.
module tb_op_mode_commit_ctrl;

  localparam logic [2:0] OP_SINGLE = 3'd0, OP_DOUBLE = 3'd1, OP_SCALAR = 3'd2;
  localparam logic [2:0] C_TRANS = 3'd0, C_ADD = 3'd1, C_MUL = 3'd2, C_SMUL = 3'd3;
  localparam logic [1:0] EV_COMMIT = 2'd1, EV_INVALID = 2'd2, EV_LOCK = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] switches = 8'h00;
  logic       confirm_btn = 1'b0;
  logic       calc_busy = 1'b0;
  logic       cfg_ack = 1'b0;
  logic [2:0] op_mode;
  logic [2:0] calc_type;
  logic       mode_valid;
  logic       cfg_req;
  logic       invalid_code;
  logic       lock_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q[$];
  logic req_prev = 1'b0;
  int   req_len = 0;
  int   last_req_len = 0;

  op_mode_commit_ctrl #(
    .SW_WIDTH(8), .CODE_LSB(0), .CODE_WIDTH(3), .NUM_MODES(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .switches(switches), .confirm_btn(confirm_btn),
    .calc_busy(calc_busy), .op_mode(op_mode), .calc_type(calc_type),
    .mode_valid(mode_valid), .cfg_req(cfg_req), .cfg_ack(cfg_ack),
    .invalid_code(invalid_code), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ev(input logic [1:0] k, input logic [2:0] o, input logic [2:0] c);
    return {k, o, c};
  endfunction

  task automatic sb_match(input logic [7:0] obs);
    if (sb_q.size() == 0) check_eq("sb_unexpected", 32'(obs), 32'd0);
    else check_eq("sb_event", 32'(obs), 32'(sb_q.pop_front()));
  endtask

  // Event monitor on the falling edge
  always @(negedge clk) begin
    if (cfg_req && !req_prev) sb_match(ev(EV_COMMIT, op_mode, calc_type));
    if (invalid_code) sb_match(ev(EV_INVALID, op_mode, calc_type));
    if (lock_err) sb_match(ev(EV_LOCK, op_mode, calc_type));
    if (cfg_req) req_len = req_len + 1;
    else if (req_prev) begin
      last_req_len = req_len;
      req_len = 0;
    end
    req_prev = cfg_req;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [7:0] v);
    @(posedge clk); #1 switches = v;
    cycles(3);
  endtask

  task automatic press(input int n_high);
    @(posedge clk); #1 confirm_btn = 1'b1;
    cycles(n_high);
    confirm_btn = 1'b0;
    cycles(14);
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1 cfg_ack = 1'b1;
    @(posedge clk); #1 cfg_ack = 1'b0;
    check_eq("req_drop_after_ack", 32'(cfg_req), 32'd0);
  endtask

  task automatic check_mode(input string tag, input logic [2:0] o, input logic [2:0] c);
    check_eq({tag, "_op"}, 32'(op_mode), 32'(o));
    check_eq({tag, "_calc"}, 32'(calc_type), 32'(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset and idle
    cycles(3);
    rst = 1'b0;
    cycles(20);
    check_mode("reset", OP_SINGLE, C_TRANS);
    check_eq("reset_valid", 32'(mode_valid), 32'd0);
    check_eq("reset_req", 32'(cfg_req), 32'd0);

    // 2: commit code 2
    set_sw(8'h02);
    sb_q.push_back(ev(EV_COMMIT, OP_DOUBLE, C_MUL));
    press(10);
    check_mode("commit2", OP_DOUBLE, C_MUL);
    check_eq("commit2_valid", 32'(mode_valid), 32'd1);
    check_eq("commit2_req", 32'(cfg_req), 32'd1);
    ack_pulse();

    // 3: glitch rejected, then code 1 with a long hold commits once
    press(3);
    check_mode("glitch", OP_DOUBLE, C_MUL);
    check_eq("glitch_req", 32'(cfg_req), 32'd0);
    set_sw(8'h01);
    sb_q.push_back(ev(EV_COMMIT, OP_DOUBLE, C_ADD));
    press(30);
    check_mode("commit1", OP_DOUBLE, C_ADD);
    check_eq("commit1_req", 32'(cfg_req), 32'd1);
    ack_pulse();

    // 4: out-of-range code
    set_sw(8'h05);
    sb_q.push_back(ev(EV_INVALID, OP_DOUBLE, C_ADD));
    press(8);
    check_mode("invalid", OP_DOUBLE, C_ADD);
    check_eq("invalid_req", 32'(cfg_req), 32'd0);

    // 5a: press while datapath busy
    calc_busy = 1'b1;
    set_sw(8'h03);
    sb_q.push_back(ev(EV_LOCK, OP_DOUBLE, C_ADD));
    press(8);
    calc_busy = 1'b0;
    check_mode("busy", OP_DOUBLE, C_ADD);
    check_eq("busy_req", 32'(cfg_req), 32'd0);

    // 5b: press while handshake pending
    set_sw(8'h00);
    sb_q.push_back(ev(EV_COMMIT, OP_SINGLE, C_TRANS));
    press(8);
    set_sw(8'h03);
    sb_q.push_back(ev(EV_LOCK, OP_SINGLE, C_TRANS));
    press(8);
    check_mode("pending", OP_SINGLE, C_TRANS);
    check_eq("pending_req", 32'(cfg_req), 32'd1);
    ack_pulse();
    check_mode("pending_after_ack", OP_SINGLE, C_TRANS);

    // ack already high when req rises: req lasts exactly one cycle
    cfg_ack = 1'b1;
    set_sw(8'h01);
    sb_q.push_back(ev(EV_COMMIT, OP_DOUBLE, C_ADD));
    press(8);
    cfg_ack = 1'b0;
    check_eq("early_ack_req_len", 32'(last_req_len), 32'd1);
    check_mode("early_ack", OP_DOUBLE, C_ADD);

    // 6: commit code 3, reset mid-handshake
    set_sw(8'h03);
    sb_q.push_back(ev(EV_COMMIT, OP_SCALAR, C_SMUL));
    press(8);
    check_mode("commit3", OP_SCALAR, C_SMUL);
    check_eq("commit3_req", 32'(cfg_req), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_mode("midreset", OP_SINGLE, C_TRANS);
    check_eq("midreset_valid", 32'(mode_valid), 32'd0);
    check_eq("midreset_req", 32'(cfg_req), 32'd0);
    cfg_ack = 1'b1;
    cycles(2);
    cfg_ack = 1'b0;
    cycles(10);
    check_mode("post_reset_ack", OP_SINGLE, C_TRANS);
    check_eq("post_reset_ack_req", 32'(cfg_req), 32'd0);
    check_eq("post_reset_ack_valid", 32'(mode_valid), 32'd0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
